// File: rtl/seqmul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seqmul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Constant-evaluable ceiling log2, used to size the step counter.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_READY = 1'b1;
    localparam logic   RST_BUSY  = 1'b0;
    localparam logic   RST_DONE  = 1'b0;

endpackage

// File: rtl/seqmul_step.sv
// One shift-add step: add (or subtract on the signed final step) M into ACC,
// then shift {sum, Q} right by one with the adder's top bit entering the MSB.
module seqmul_step #(
    parameter int W = 4
) (
    input  logic [W-1:0] m,
    input  logic [W-1:0] acc,
    input  logic [W-1:0] q,
    input  logic         last,
    input  logic         sgn,
    output logic [W-1:0] acc_next,
    output logic [W-1:0] q_next
);

    logic [W:0] ext_m;
    logic [W:0] ext_acc;
    logic [W:0] addend;
    logic [W:0] sum;

    // The W+1-bit sum holds the unsigned carry or the true signed sign bit,
    // so one shift serves both modes.
    always_comb begin
        ext_m    = {sgn & m[W-1], m};
        ext_acc  = {sgn & acc[W-1], acc};
        addend   = q[0] ? ext_m : '0;
        sum      = (sgn && last) ? (ext_acc - addend) : (ext_acc + addend);
        acc_next = sum[W:1];
        q_next   = {sum[0], q[W-1:1]};
    end

endmodule

// File: rtl/seqmul_shift_add.sv
// Sequential W x W shift-add multiplier with START/READY/DONE handshake.
// Defining SEQMUL_SIGNED_EN adds the SGN input for two's-complement operands.
module seqmul_shift_add
    import seqmul_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           CK,
    input  logic           RN,
    input  logic           START,
`ifdef SEQMUL_SIGNED_EN
    input  logic           SGN,
`endif
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           READY,
    output logic           BUSY,
    output logic           DONE,
    output logic [2*W-1:0] P
);

    localparam int CW = clog2(W + 1);

    state_t        state;
    logic [W-1:0]  m;
    logic [W-1:0]  acc;
    logic [W-1:0]  q;
    logic [CW-1:0] cnt;
    logic          sgn_r;
    logic          last;
    logic [W-1:0]  acc_next;
    logic [W-1:0]  q_next;
    logic          sgn_in;

`ifdef SEQMUL_SIGNED_EN
    assign sgn_in = SGN;
`else
    assign sgn_in = 1'b0;
`endif

    assign last = (cnt == CW'(W - 1));

    seqmul_step #(.W(W)) u_step (
        .m        (m),
        .acc      (acc),
        .q        (q),
        .last     (last),
        .sgn      (sgn_r),
        .acc_next (acc_next),
        .q_next   (q_next)
    );

    // READY/BUSY/DONE are registered alongside the state they describe.
    always_ff @(posedge CK) begin
        if (!RN) begin
            state <= RST_STATE;
            m     <= '0;
            acc   <= '0;
            q     <= '0;
            cnt   <= '0;
            sgn_r <= 1'b0;
            P     <= '0;
            READY <= RST_READY;
            BUSY  <= RST_BUSY;
            DONE  <= RST_DONE;
        end else begin
            case (state)
                seqmul_pkg::IDLE, seqmul_pkg::DONE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        m     <= A;
                        q     <= B;
                        acc   <= '0;
                        cnt   <= '0;
                        sgn_r <= sgn_in;
                        state <= seqmul_pkg::RUN;
                        READY <= 1'b0;
                        BUSY  <= 1'b1;
                    end else begin
                        state <= seqmul_pkg::IDLE;
                        READY <= 1'b1;
                        BUSY  <= 1'b0;
                    end
                end
                seqmul_pkg::RUN: begin
                    acc <= acc_next;
                    q   <= q_next;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        P     <= {acc_next, q_next};
                        state <= seqmul_pkg::DONE;
                        READY <= 1'b1;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
                end
                default: begin
                    state <= seqmul_pkg::IDLE;
                    READY <= 1'b1;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seqmul_shift_add.sv
// Scoreboard bench for seqmul_shift_add at W=4 and W=8.
module tb_seqmul_shift_add;

    logic       ck;
    logic       rn;
    logic       start4, sgn4, ready4, busy4, done4;
    logic [3:0] a4, b4;
    logic [7:0] p4;
    logic       start8, ready8, busy8, done8;
    logic [7:0] a8, b8;
    logic [15:0] p8;

    int checks = 0;
    int errors = 0;
    int dones4 = 0;
    int dones8 = 0;
    logic [7:0]  exp4_q[$];
    logic [15:0] exp8_q[$];

    seqmul_shift_add #(.W(4)) dut4 (
        .CK(ck), .RN(rn), .START(start4),
`ifdef SEQMUL_SIGNED_EN
        .SGN(sgn4),
`endif
        .A(a4), .B(b4), .READY(ready4), .BUSY(busy4), .DONE(done4), .P(p4)
    );

    seqmul_shift_add #(.W(8)) dut8 (
        .CK(ck), .RN(rn), .START(start8),
`ifdef SEQMUL_SIGNED_EN
        .SGN(1'b0),
`endif
        .A(a8), .B(b8), .READY(ready8), .BUSY(busy8), .DONE(done8), .P(p8)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model4(input logic [3:0] a, input logic [3:0] b, input logic s);
        int sa, sb;
        sa = (s && a[3]) ? int'(a) - 16 : int'(a);
        sb = (s && b[3]) ? int'(b) - 16 : int'(b);
        return 8'(sa * sb);
    endfunction

    always @(negedge ck) begin
        if (rn && done4) begin
            dones4++;
            check("sb4_nonempty", 32'(exp4_q.size() != 0), 1);
            if (exp4_q.size() != 0) check("p4", p4, exp4_q.pop_front());
        end
        if (rn && done8) begin
            dones8++;
            check("sb8_nonempty", 32'(exp8_q.size() != 0), 1);
            if (exp8_q.size() != 0) check("p8", p8, exp8_q.pop_front());
        end
    end

    task automatic wait_done4(output int lat);
        lat = 0;
        do begin
            @(negedge ck);
            lat++;
        end while (!done4 && lat < 20);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s, output int lat);
        int guard;
        guard = 0;
        @(negedge ck);
        while (!ready4 && guard < 20) begin
            @(negedge ck);
            guard++;
        end
        start4 = 1'b1; a4 = a; b4 = b; sgn4 = s;
        exp4_q.push_back(model4(a, b, s));
        @(posedge ck);
        #1 start4 = 1'b0;
        wait_done4(lat);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, output int lat);
        @(negedge ck);
        start8 = 1'b1; a8 = a; b8 = b;
        exp8_q.push_back(16'(int'(a) * int'(b)));
        @(posedge ck);
        #1 start8 = 1'b0;
        lat = 0;
        do begin
            @(negedge ck);
            lat++;
        end while (!done8 && lat < 30);
    endtask

    initial begin
        int lat, d0;
        rn = 1'b0; start4 = 1'b0; sgn4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(negedge ck);
        check("rst_ready", ready4, 1);
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_p", p4, 0);
        rn = 1'b1;

        // 15*15 with RUN-phase handshake and P-hold checks
        @(negedge ck);
        start4 = 1'b1; a4 = 4'd15; b4 = 4'd15;
        exp4_q.push_back(8'hE1);
        @(posedge ck);
        #1 start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge ck);
            check("run_ready", ready4, 0);
            check("run_busy", busy4, 1);
            check("run_done", done4, 0);
            check("run_p_hold", p4, 0);
        end
        @(negedge ck);
        check("done_lat_15x15", done4, 1);
        check("done_ready", ready4, 1);
        @(negedge ck);
        check("done_pulse_1cyc", done4, 0);

        // back-to-back: 9*6 then 0*13 accepted in the DONE cycle
        start4 = 1'b1; a4 = 4'd9; b4 = 4'd6;
        exp4_q.push_back(8'd54);
        @(posedge ck);
        #1 a4 = 4'd0; b4 = 4'd13;
        wait_done4(lat);
        check("b2b_lat1", lat, 5);
        exp4_q.push_back(8'd0);
        @(posedge ck);
        #1 start4 = 1'b0;
        wait_done4(lat);
        check("b2b_lat2", lat, 5);

        // START mid-RUN is ignored
        @(negedge ck);
        start4 = 1'b1; a4 = 4'd7; b4 = 4'd3;
        exp4_q.push_back(8'd21);
        @(posedge ck);
        #1 start4 = 1'b0;
        repeat (2) @(negedge ck);
        start4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
        @(negedge ck);
        start4 = 1'b0;
        d0 = dones4;
        wait_done4(lat);
        repeat (6) @(negedge ck);
        check("ignore_one_done", dones4 - d0, 1);

        // reset in the 2nd RUN cycle discards the operation
        @(negedge ck);
        start4 = 1'b1; a4 = 4'd5; b4 = 4'd5;
        @(posedge ck);
        #1 start4 = 1'b0;
        repeat (2) @(negedge ck);
        rn = 1'b0;
        @(negedge ck);
        check("mid_rst_ready", ready4, 1);
        check("mid_rst_busy", busy4, 0);
        check("mid_rst_p", p4, 0);
        rn = 1'b1;
        d0 = dones4;
        repeat (8) @(negedge ck);
        check("mid_rst_no_done", dones4 - d0, 0);

        // random unsigned operands, including zero and all-ones
        for (int i = 0; i < 10; i++) begin
            op4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, lat);
            check("rand4_lat", lat, 5);
        end

`ifdef SEQMUL_SIGNED_EN
        op4(4'hD, 4'd5, 1'b1, lat);
        check("sgn_lat", lat, 5);
        check("sgn_m3x5", p4, 8'hF1);
        op4(4'h8, 4'h8, 1'b1, lat);
        check("sgn_m8xm8", p4, 8'd64);
        op4(4'd12, 4'd12, 1'b0, lat);
        check("uns_12x12", p4, 8'd144);
        for (int i = 0; i < 8; i++) begin
            op4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1, lat);
        end
`endif

        // W=8 instance
        op8(8'd255, 8'd255, lat);
        check("w8_lat", lat, 9);
        check("w8_ffxff", p8, 16'hFE01);
        op8(8'd128, 8'd2, lat);
        check("w8_128x2", p8, 16'd256);
        for (int i = 0; i < 6; i++) begin
            op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), lat);
            check("w8_rand_lat", lat, 9);
        end

        repeat (3) @(negedge ck);
        check("sb4_drained", exp4_q.size(), 0);
        check("sb8_drained", exp8_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
